id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage directly upstream of the 12-bit one-hot ALU.
- Accepts 32-bit MIPS-subset instructions over a valid/ready handshake and reads the internal 32x32 register file.
- Produces registered alu_op / alu_src1 / alu_src2 / dest toward the execute stage.
- Accepts a writeback port that updates the register file.

Parameters:
- NREG, 32, register count; fixes the 5-bit register index.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fs_valid  in  1  instruction valid from fetch.
- fs_inst  in  32  instruction word.
- ds_ready  out  1  stage can accept an instruction this cycle.
- es_valid  out  1  outputs below hold a decoded instruction.
- es_ready  in  1  execute stage consumes this cycle.
- alu_op  out  12  one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui.
- alu_src1  out  32  ALU operand 1.
- alu_src2  out  32  ALU operand 2.
- dest  out  5  destination register; 0 means no write.
- wb_we  in  1  writeback enable.
- wb_waddr  in  5  writeback register index.
- wb_wdata  in  32  writeback data.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: es_valid=0; alu_op, alu_src1, alu_src2 and dest all 0; all 32 registers cleared to 0.
- Handshake:
  - ds_ready = !es_valid || es_ready (combinational).
  - Transfer occurs when fs_valid && ds_ready. The decoded result is registered and es_valid=1 on the next edge. Latency is 1 cycle.
  - If there is no transfer and es_ready=1, es_valid goes to 0.
  - While es_valid && !es_ready, all outputs hold stable.
  - Back-to-back transfers give full throughput, one instruction per cycle.
- Register file:
  - Two combinational read ports, rs=inst[25:21] and rt=inst[20:16].
  - r0 always reads 0; writes to r0 are ignored.
  - Write on the edge when wb_we=1 and wb_waddr!=0.
  - Write-through: if wb_we && wb_waddr==rs (or rt) && wb_waddr!=0 in the same cycle, the read returns wb_wdata.
  - No other hazard detection is performed.
- Decode, R-type (opcode 000000), alu_src1=rs, alu_src2=rt, dest=rd:
  - funct 100001 addu -> add
  - funct 100011 subu -> sub
  - funct 101010 slt -> slt
  - funct 101011 sltu -> sltu
  - funct 100100 and -> and
  - funct 100111 nor -> nor
  - funct 100101 or -> or
  - funct 100110 xor -> xor
- Shifts: sll (funct 000000), srl (000010), sra (000011).
  - alu_src1 = {27'b0, inst[10:6]}, alu_src2 = rt, dest = rd.
- I-type, dest = rt, imm = inst[15:0]:
  - addiu 001001 -> add, alu_src1=rs, alu_src2=sign-extended imm.
  - slti 001010 -> slt, operands as addiu.
  - sltiu 001011 -> sltu, operands as addiu (sign-extended imm, unsigned compare).
  - ori 001101 -> or, alu_src1=rs, alu_src2=zero-extended imm.
  - lui 001111 -> lui, alu_src1=0, alu_src2={16'b0, imm}; the ALU produces src2<<16.
- Unrecognised encodings: alu_op=0, dest=0, both sources 0; still transferred with es_valid=1 and acts as a NOP.
- Boundary cases:
  - Reset while stalled clears es_valid and drops the held instruction.
  - A writeback during a stall does not alter the held outputs.
  - fs_inst is ignored when fs_valid=0.

Test Plan:
- Reset, then wb r1=1 and r2=1; send addu r3,r1,r2 (0x00221821) with es_ready=1. Next cycle: es_valid=1, alu_op=12'h800, src1=1, src2=1, dest=3.
- Send lui r4,0xbfc0 (0x3C04BFC0). Expect alu_op=12'h001, src1=0, src2=32'h0000bfc0, dest=4.
- Send sll r5,r2,4 (0x00022900) with r2=1. Expect alu_op=12'h008, src1=4, src2=1, dest=5.
- Send addiu r6,r0,-1 (0x2406FFFF). Expect alu_op=12'h800, src1=0, src2=32'hffffffff. Send ori with imm 0xffff; expect src2=32'h0000ffff.
- Hold es_ready=0 with two instructions offered. Expect ds_ready=0 and outputs stable across 3 cycles. Raise es_ready; expect the second instruction on the next cycle with none lost or duplicated.
- Same-cycle wb r7=0x1234 while decoding or r8,r7,r0 (0x00E04025). Expect src1=0x1234. wb to r0 with 5; a later read of r0 gives 0. Assert reset mid-stall; expect es_valid=0.

Source files
------------

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : instruction decode stage feeding the one-hot ALU.
//
// Decodes a MIPS subset (R-type ALU ops, shifts, addiu/slti/sltiu/ori/lui),
// reads operands from an internal 32x32 register file, and presents the
// result to the execute stage through a registered valid/ready interface.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   fs_valid, fs_inst   instruction offered by fetch
//   ds_ready            this stage can accept an instruction this cycle
//   es_valid, es_ready  handshake toward execute
//   alu_op              one-hot ALU select
//                       [11]add [10]sub [9]slt [8]sltu [7]and [6]nor
//                       [5]or [4]xor [3]sll [2]srl [1]sra [0]lui
//   alu_src1, alu_src2  ALU operands
//   dest                destination register (0 = no write)
//   wb_we/waddr/wdata   register file writeback port
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_valid,
  input  logic [31:0] fs_inst,
  output logic        ds_ready,
  output logic        es_valid,
  input  logic        es_ready,
  output logic [11:0] alu_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [4:0]  dest,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata
);

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  logic [31:0] rf_q [NREG];
  logic [31:0] rf_d [NREG];

  logic        es_valid_q, es_valid_d;
  logic [11:0] alu_op_q, alu_op_d;
  logic [31:0] alu_src1_q, alu_src1_d;
  logic [31:0] alu_src2_q, alu_src2_d;
  logic [4:0]  dest_q, dest_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
  logic [11:0] dec_op;
  logic [31:0] dec_src1, dec_src2;
  logic [4:0]  dec_dest;
  logic        transfer;

  assign opcode   = fs_inst[31:26];
  assign rs       = fs_inst[25:21];
  assign rt       = fs_inst[20:16];
  assign rd       = fs_inst[15:11];
  assign shamt    = fs_inst[10:6];
  assign funct    = fs_inst[5:0];
  assign imm      = fs_inst[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  assign ds_ready = !es_valid_q || es_ready;
  assign transfer = fs_valid && ds_ready;

  // Read ports; a same-cycle writeback to the register being read is
  // forwarded so the decoded operand is never one write stale.
  always_comb begin
    rs_val = rf_q[rs];
    rt_val = rf_q[rt];
    if (wb_we && wb_waddr == rs) rs_val = wb_wdata;
    if (wb_we && wb_waddr == rt) rt_val = wb_wdata;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_waddr != 5'd0) rf_d[wb_waddr] = wb_wdata;
  end

  // Unrecognised encodings fall through with everything zero (a NOP).
  always_comb begin
    dec_op   = '0;
    dec_src1 = '0;
    dec_src2 = '0;
    dec_dest = '0;
    case (opcode)
      6'b000000: begin
        dec_src1 = rs_val;
        dec_src2 = rt_val;
        dec_dest = rd;
        case (funct)
          6'b100001: dec_op = OP_ADD;
          6'b100011: dec_op = OP_SUB;
          6'b101010: dec_op = OP_SLT;
          6'b101011: dec_op = OP_SLTU;
          6'b100100: dec_op = OP_AND;
          6'b100111: dec_op = OP_NOR;
          6'b100101: dec_op = OP_OR;
          6'b100110: dec_op = OP_XOR;
          6'b000000: dec_op = OP_SLL;
          6'b000010: dec_op = OP_SRL;
          6'b000011: dec_op = OP_SRA;
          default:   dec_op = '0;
        endcase
        // Shifts take the shift amount from the instruction, not rs.
        if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011)
          dec_src1 = {27'b0, shamt};
        if (dec_op == '0) begin
          dec_src1 = '0;
          dec_src2 = '0;
          dec_dest = '0;
        end
      end
      6'b001001: begin dec_op = OP_ADD;  dec_src1 = rs_val; dec_src2 = imm_sext; dec_dest = rt; end
      6'b001010: begin dec_op = OP_SLT;  dec_src1 = rs_val; dec_src2 = imm_sext; dec_dest = rt; end
      6'b001011: begin dec_op = OP_SLTU; dec_src1 = rs_val; dec_src2 = imm_sext; dec_dest = rt; end
      6'b001101: begin dec_op = OP_OR;   dec_src1 = rs_val; dec_src2 = imm_zext; dec_dest = rt; end
      6'b001111: begin dec_op = OP_LUI;  dec_src1 = '0;     dec_src2 = imm_zext; dec_dest = rt; end
      default: ;
    endcase
  end

  // Output register: load on transfer, drop valid when consumed, else hold.
  always_comb begin
    es_valid_d = es_valid_q;
    alu_op_d   = alu_op_q;
    alu_src1_d = alu_src1_q;
    alu_src2_d = alu_src2_q;
    dest_d     = dest_q;
    if (transfer) begin
      es_valid_d = 1'b1;
      alu_op_d   = dec_op;
      alu_src1_d = dec_src1;
      alu_src2_d = dec_src2;
      dest_d     = dec_dest;
    end else if (es_ready) begin
      es_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      alu_op_q   <= '0;
      alu_src1_q <= '0;
      alu_src2_q <= '0;
      dest_q     <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      alu_op_q   <= alu_op_d;
      alu_src1_q <= alu_src1_d;
      alu_src2_q <= alu_src2_d;
      dest_q     <= dest_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign es_valid = es_valid_q;
  assign alu_op   = alu_op_q;
  assign alu_src1 = alu_src1_q;
  assign alu_src2 = alu_src2_q;
  assign dest     = dest_q;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage : directed, table-driven bench for id_stage, with hand-written
// sequences for stall, resume and reset-during-stall.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_valid;
  logic [31:0] fs_inst;
  logic        ds_ready;
  logic        es_valid;
  logic        es_ready;
  logic [11:0] alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  dest;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int n_compared = 0;
  int n_mismatched = 0;

  id_stage #(.NREG(32)) dut (
    .clk(clk), .reset(reset),
    .fs_valid(fs_valid), .fs_inst(fs_inst), .ds_ready(ds_ready),
    .es_valid(es_valid), .es_ready(es_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .dest(dest),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        fs_valid;
    logic [31:0] inst;
    logic        es_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [11:0] exp_op;
    logic [31:0] exp_s1;
    logic [31:0] exp_s2;
    logic [4:0]  exp_dest;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                              logic fv, logic [31:0] inst, logic er,
                              logic ev, logic cd, logic [11:0] op,
                              logic [31:0] s1, logic [31:0] s2, logic [4:0] d);
    vec_t v;
    v.wb_we = we; v.wb_waddr = wa; v.wb_wdata = wd;
    v.fs_valid = fv; v.inst = inst; v.es_ready = er;
    v.exp_valid = ev; v.chk_data = cd; v.exp_op = op;
    v.exp_s1 = s1; v.exp_s2 = s2; v.exp_dest = d;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(logic we, logic [4:0] wa, logic [31:0] wd,
                               logic fv, logic [31:0] inst, logic er);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    fs_valid = fv; fs_inst = inst; es_ready = er;
  endtask

  task automatic checkOutput(string tag, logic ev, logic cd, logic [11:0] op,
                             logic [31:0] s1, logic [31:0] s2, logic [4:0] d);
    chk({tag, ".es_valid"}, {31'b0, es_valid}, {31'b0, ev});
    if (cd) begin
      chk({tag, ".alu_op"},   {20'b0, alu_op}, {20'b0, op});
      chk({tag, ".alu_src1"}, alu_src1, s1);
      chk({tag, ".alu_src2"}, alu_src2, s2);
      chk({tag, ".dest"},     {27'b0, dest}, {27'b0, d});
    end
  endtask

  // One cycle: drive, take the edge, sample 1ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 5'd1, 32'd1, 0, 32'h0,        1, 0, 1, 12'h000, 32'h0, 32'h0, 5'd0);
    vecs[1]  = mk(1, 5'd2, 32'd1, 0, 32'h0,        1, 0, 0, 12'h000, 32'h0, 32'h0, 5'd0);
    vecs[2]  = mk(0, 5'd0, 32'd0, 1, 32'h00221821, 1, 1, 1, 12'h800, 32'h1, 32'h1, 5'd3);
    vecs[3]  = mk(0, 5'd0, 32'd0, 1, 32'h3C04BFC0, 1, 1, 1, 12'h001, 32'h0, 32'h0000bfc0, 5'd4);
    vecs[4]  = mk(0, 5'd0, 32'd0, 1, 32'h00022900, 1, 1, 1, 12'h008, 32'h4, 32'h1, 5'd5);
    vecs[5]  = mk(0, 5'd0, 32'd0, 1, 32'h2406FFFF, 1, 1, 1, 12'h800, 32'h0, 32'hffffffff, 5'd6);
    vecs[6]  = mk(0, 5'd0, 32'd0, 1, 32'h3409FFFF, 1, 1, 1, 12'h020, 32'h0, 32'h0000ffff, 5'd9);
    vecs[7]  = mk(0, 5'd0, 32'd0, 1, 32'h282AFFFE, 1, 1, 1, 12'h200, 32'h1, 32'hfffffffe, 5'd10);
    vecs[8]  = mk(0, 5'd0, 32'd0, 1, 32'h2C2B0005, 1, 1, 1, 12'h100, 32'h1, 32'h5, 5'd11);
    vecs[9]  = mk(0, 5'd0, 32'd0, 1, 32'h00226023, 1, 1, 1, 12'h400, 32'h1, 32'h1, 5'd12);
    vecs[10] = mk(0, 5'd0, 32'd0, 1, 32'h00226827, 1, 1, 1, 12'h040, 32'h1, 32'h1, 5'd13);
    vecs[11] = mk(0, 5'd0, 32'd0, 0, 32'h0,        1, 0, 0, 12'h000, 32'h0, 32'h0, 5'd0);
    vecs[12] = mk(0, 5'd0, 32'd0, 1, 32'hFC000000, 1, 1, 1, 12'h000, 32'h0, 32'h0, 5'd0);
    vecs[13] = mk(0, 5'd0, 32'd0, 0, 32'h00221821, 1, 0, 0, 12'h000, 32'h0, 32'h0, 5'd0);
    vecs[14] = mk(1, 5'd7, 32'h1234, 1, 32'h00E04025, 1, 1, 1, 12'h020, 32'h1234, 32'h0, 5'd8);
    vecs[15] = mk(1, 5'd0, 32'd5, 1, 32'h00007021, 1, 1, 1, 12'h800, 32'h0, 32'h0, 5'd14);
    vecs[16] = mk(0, 5'd0, 32'd0, 1, 32'h00077821, 1, 1, 1, 12'h800, 32'h0, 32'h1234, 5'd15);
    vecs[17] = mk(0, 5'd0, 32'd0, 1, 32'h00078043, 1, 1, 1, 12'h002, 32'h1, 32'h1234, 5'd16);
    vecs[18] = mk(0, 5'd0, 32'd0, 1, 32'h00278826, 1, 1, 1, 12'h010, 32'h1, 32'h1234, 5'd17);
    vecs[19] = mk(0, 5'd0, 32'd0, 1, 32'h00E1902B, 1, 1, 1, 12'h100, 32'h1234, 32'h1, 5'd18);

    // Reset and check cleared outputs.
    reset = 1'b1;
    applyStimulus(0, 5'd0, 32'd0, 0, 32'h0, 1);
    cycle();
    cycle();
    checkOutput("reset", 0, 1, 12'h000, 32'h0, 32'h0, 5'd0);
    chk("reset.ds_ready", {31'b0, ds_ready}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].wb_we, vecs[i].wb_waddr, vecs[i].wb_wdata,
                    vecs[i].fs_valid, vecs[i].inst, vecs[i].es_ready);
      cycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].chk_data,
                  vecs[i].exp_op, vecs[i].exp_s1, vecs[i].exp_s2, vecs[i].exp_dest);
    end

    // Stall: and r19,r1,r2 accepted, then srl r20,r2,3 offered while
    // execute is not ready; a writeback to r1 must not disturb the held op.
    applyStimulus(0, 5'd0, 32'd0, 1, 32'h00229824, 1);
    cycle();
    checkOutput("stallA", 1, 1, 12'h080, 32'h1, 32'h1, 5'd19);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 5'd1, 32'h55, 1, 32'h0002A0C2, 0);
      #1;
      chk($sformatf("stall%0d.ds_ready", k), {31'b0, ds_ready}, 32'd0);
      cycle();
      checkOutput($sformatf("stall%0d", k), 1, 1, 12'h080, 32'h1, 32'h1, 5'd19);
    end
    applyStimulus(0, 5'd0, 32'd0, 1, 32'h0002A0C2, 1);
    #1;
    chk("resume.ds_ready", {31'b0, ds_ready}, 32'd1);
    cycle();
    checkOutput("resumeB", 1, 1, 12'h004, 32'h3, 32'h1, 5'd20);
    applyStimulus(0, 5'd0, 32'd0, 0, 32'h0, 1);
    cycle();
    checkOutput("noDup", 0, 0, 12'h000, 32'h0, 32'h0, 5'd0);

    // Reset while stalled drops the held instruction and clears registers.
    applyStimulus(0, 5'd0, 32'd0, 1, 32'h00221821, 1);
    cycle();
    checkOutput("preRst", 1, 1, 12'h800, 32'h55, 32'h1, 5'd3);
    applyStimulus(0, 5'd0, 32'd0, 1, 32'h00226023, 0);
    cycle();
    checkOutput("preRstHold", 1, 1, 12'h800, 32'h55, 32'h1, 5'd3);
    reset = 1'b1;
    cycle();
    checkOutput("midStallRst", 0, 1, 12'h000, 32'h0, 32'h0, 5'd0);
    reset = 1'b0;
    applyStimulus(0, 5'd0, 32'd0, 1, 32'h00221821, 1);
    cycle();
    checkOutput("rfCleared", 1, 1, 12'h800, 32'h0, 32'h0, 5'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
